// File: rtl/board_writer.sv
// board_writer: executes chess-board commands against a 64-word board memory.
//   MOVE      copy the piece bits from one square to another, then empty the source
//   HIGHLIGHT recolour one square (colour 0 restores the base colour)
//   CLEAR_HL  restore the base colour of all 64 squares, keeping the pieces
//   INIT      write the standard starting position
// Ports:
//   iCLK, iRST_n                  clock, synchronous active-low reset
//   iCmd_valid/oCmd_ready         command handshake (ready only when idle)
//   iCmd_op, iFrom, iTo, iColor   command fields, latched on acceptance
//   oMemAddr/oMemWData/oMemWE     board memory port; iMemRData valid one cycle after a read address
//   oBusy, oDone                  command in progress / one-cycle completion pulse
module board_writer (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iCmd_valid,
    output logic        oCmd_ready,
    input  logic [1:0]  iCmd_op,
    input  logic [5:0]  iFrom,
    input  logic [5:0]  iTo,
    input  logic [3:0]  iColor,
    output logic [11:0] oMemAddr,
    output logic [31:0] oMemWData,
    output logic        oMemWE,
    input  logic [31:0] iMemRData,
    output logic        oBusy,
    output logic        oDone
);
    localparam int unsigned SQ_W   = 6;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned COL_W  = 4;

    localparam logic [1:0] OP_MOVE  = 2'b00;
    localparam logic [1:0] OP_HL    = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_INIT  = 2'b11;

    localparam logic [SQ_W-1:0] LAST_SQ = SQ_W'(63);

    // S_START: one idle cycle before a sweep, and the whole body of a null move
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_RD, S_WAIT, S_WR1, S_WR2, S_INIT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [SQ_W-1:0]   from_q, from_d;
    logic [SQ_W-1:0]   to_q, to_d;
    logic [COL_W-1:0]  color_q, color_d;
    logic [SQ_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic [SQ_W-1:0]   addr_sq;
    logic [7:0]        wr_byte;
    logic [COL_W-1:0]  colour_sel;

    // Only the piece nibble of a read word is ever reused
    logic unused_rdata;
    assign unused_rdata = ^iMemRData[31:4];

    // (row + col) is even exactly when row[0] == col[0]
    function automatic logic [COL_W-1:0] base_colour(input logic row_lsb, input logic col_lsb);
        return (row_lsb ^ col_lsb) ? 4'b0100 : 4'b1000;
    endfunction

    // Starting-position word for a square: {base colour, type, side}
    function automatic logic [7:0] init_word(input logic [SQ_W-1:0] sq);
        logic [2:0] back;
        logic [2:0] kind;
        logic       side;
        back = 3'd3;
        kind = 3'd7;
        side = 1'b0;
        case (sq[2:0])
            3'd0, 3'd7: back = 3'd3;
            3'd1, 3'd6: back = 3'd1;
            3'd2, 3'd5: back = 3'd2;
            3'd3:       back = 3'd4;
            default:    back = 3'd5;
        endcase
        case (sq[5:3])
            3'd0:    begin kind = back; side = 1'b0; end
            3'd1:    begin kind = 3'd0; side = 1'b0; end
            3'd6:    begin kind = 3'd0; side = 1'b1; end
            3'd7:    begin kind = back; side = 1'b1; end
            default: begin kind = 3'd7; side = 1'b0; end
        endcase
        return {base_colour(sq[3], sq[0]), kind, side};
    endfunction

    // Next state, command latch, and the registered memory/handshake outputs
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        from_d  = from_q;
        to_d    = to_q;
        color_d = color_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (iCmd_valid) begin
                    op_d    = iCmd_op;
                    from_d  = iFrom;
                    to_d    = iTo;
                    color_d = iColor;
                    cnt_d   = '0;
                    case (iCmd_op)
                        OP_MOVE: state_d = (iFrom == iTo) ? S_START : S_RD;
                        OP_HL:   state_d = S_RD;
                        default: state_d = S_START;
                    endcase
                end
            end
            S_START: begin
                case (op_q)
                    OP_MOVE: state_d = S_DONE;
                    OP_INIT: state_d = S_INIT;
                    default: state_d = S_RD;
                endcase
            end
            S_RD:   state_d = S_WAIT;
            S_WAIT: state_d = S_WR1;
            S_WR1: begin
                if (op_q == OP_MOVE) begin
                    state_d = S_WR2;
                end else if ((op_q == OP_CLEAR) && (cnt_q != LAST_SQ)) begin
                    cnt_d   = cnt_q + SQ_W'(1);
                    state_d = S_RD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WR2: state_d = S_DONE;
            S_INIT: begin
                if (cnt_q == LAST_SQ) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + SQ_W'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
        endcase

        addr_sq    = '0;
        wr_byte    = '0;
        we_d       = 1'b0;
        colour_sel = '0;
        unique case (state_d)
            S_RD, S_WAIT: begin
                addr_sq = (op_d == OP_MOVE) ? from_d : ((op_d == OP_HL) ? to_d : cnt_d);
            end
            S_WR1: begin
                // read data for this square is on iMemRData during S_WAIT
                addr_sq    = (op_d == OP_CLEAR) ? cnt_d : to_d;
                colour_sel = ((op_d == OP_HL) && (color_d != '0)) ? color_d
                                                                   : base_colour(addr_sq[3], addr_sq[0]);
                wr_byte    = {colour_sel, iMemRData[3:0]};
                we_d       = 1'b1;
            end
            S_WR2: begin
                addr_sq = from_d;
                wr_byte = {base_colour(from_d[3], from_d[0]), 4'b1110};
                we_d    = 1'b1;
            end
            S_INIT: begin
                addr_sq = cnt_d;
                wr_byte = init_word(cnt_d);
                we_d    = 1'b1;
            end
            default: begin
                addr_sq = '0;
            end
        endcase

        addr_d  = ADDR_W'(addr_sq);
        wdata_d = DATA_W'(wr_byte);
        done_d  = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            from_q  <= '0;
            to_q    <= '0;
            color_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            from_q  <= from_d;
            to_q    <= to_d;
            color_q <= color_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign oCmd_ready = ready_q;
    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oMemAddr   = addr_q;
    assign oMemWData  = wdata_q;
    assign oMemWE     = we_q;

endmodule

// File: tb/tb_board_writer.sv
// tb_board_writer: drives directed and random commands into board_writer,
// serves a 64-word board memory, and checks every cycle against a
// per-command list of expected writes and the expected completion cycle.
module tb_board_writer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  from_sq;
    logic [5:0]  to_sq;
    logic [3:0]  color;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] rdata;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    board_writer dut (
        .iCLK       (clk),
        .iRST_n     (rst_n),
        .iCmd_valid (cmd_valid),
        .oCmd_ready (cmd_ready),
        .iCmd_op    (cmd_op),
        .iFrom      (from_sq),
        .iTo        (to_sq),
        .iColor     (color),
        .oMemAddr   (mem_addr),
        .oMemWData  (mem_wdata),
        .oMemWE     (mem_we),
        .iMemRData  (rdata),
        .oBusy      (busy),
        .oDone      (done)
    );

    typedef struct {
        int c;
        int a;
        int d;
    } wr_t;

    wr_t         expq[$];
    int          ref_mem[64];
    logic [31:0] mem[64];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_a = '0;
    logic [31:0] poke_d = '0;
    int          ecount = 0;
    int          acc_e = 0;
    int          done_rel = -1;
    int          n_pass = 0;
    int          n_total = 0;
    bit          mon_on = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endfunction

    // Board memory: write on strobe, registered read of the presented address
    always @(posedge clk) begin
        if (poke_en) mem[poke_a] <= poke_d;
        else if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
        rdata  <= mem[mem_addr[5:0]];
        ecount <= ecount + 1;
    end

    function automatic int base_c(int sq);
        return (((sq / 8) + (sq % 8)) % 2 == 0) ? 8 : 4;
    endfunction

    function automatic int init_w(int sq);
        int back[8] = '{3, 1, 2, 4, 5, 2, 1, 3};
        int r;
        int c;
        int ty;
        int side;
        r = sq / 8;
        c = sq % 8;
        side = (r >= 6) ? 1 : 0;
        if (r == 0 || r == 7) ty = back[c];
        else if (r == 1 || r == 6) ty = 0;
        else ty = 7;
        return base_c(sq) * 16 + ty * 2 + side;
    endfunction

    function automatic void push_wr(int c, int a, int d);
        wr_t w;
        w.c = c;
        w.a = a;
        w.d = d;
        expq.push_back(w);
    endfunction

    // Expected write list and completion cycle, relative to the acceptance edge
    function automatic void model_accept(int op, int f, int t, int c);
        expq.delete();
        acc_e = ecount + 1;
        case (op)
            0: begin
                if (f == t) done_rel = 1;
                else begin
                    push_wr(2, t, base_c(t) * 16 + ref_mem[f] % 16);
                    push_wr(3, f, base_c(f) * 16 + 14);
                    done_rel = 4;
                end
            end
            1: begin
                push_wr(2, t, ((c != 0) ? c : base_c(t)) * 16 + ref_mem[t] % 16);
                done_rel = 3;
            end
            2: begin
                for (int i = 0; i < 64; i++) push_wr(3 * i + 3, i, base_c(i) * 16 + ref_mem[i] % 16);
                done_rel = 193;
            end
            default: begin
                for (int i = 0; i < 64; i++) push_wr(i + 1, i, init_w(i));
                done_rel = 65;
            end
        endcase
    endfunction

    // Per-cycle compare against the model
    initial begin
        int rel;
        bit busy_e;
        bit wr_e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                rel    = ecount - acc_e;
                busy_e = (rel >= 0) && (rel <= done_rel);
                chk("ready", 32'(cmd_ready), 32'(!busy_e));
                chk("busy", 32'(busy), 32'(busy_e));
                chk("done", 32'(done), 32'(busy_e && (rel == done_rel)));
                wr_e = (expq.size() > 0) && (expq[0].c == rel);
                chk("we", 32'(mem_we), 32'(wr_e));
                if (wr_e) begin
                    chk("addr", 32'(mem_addr), 32'(expq[0].a));
                    chk("wdata", mem_wdata, 32'(expq[0].d));
                    ref_mem[expq[0].a] = expq[0].d;
                    void'(expq.pop_front());
                end else begin
                    chk("wdata_idle", mem_wdata, 32'd0);
                end
                if (busy_e && rel == done_rel) chk("writes_left", 32'(expq.size()), 32'd0);
            end
        end
    end

    task automatic check_reset_outputs(string tag);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic poke(input int a, input int d);
        poke_en = 1'b1;
        poke_a  = 6'(a);
        poke_d  = 32'(d);
        @(negedge clk); #1;
        poke_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Issue one command and wait (bounded) for its oDone; optional junk while busy
    task automatic do_cmd(input int op, input int f, input int t, input int c,
                          input bit junk, output int lat);
        int k;
        k = 0;
        while (!cmd_ready && k < 400) begin
            @(negedge clk); #1;
            k++;
        end
        chk("ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        from_sq   = 6'(f);
        to_sq     = 6'(t);
        color     = 4'(c);
        model_accept(op, f, t, c);
        lat = -1;
        for (int r = 0; r < 300; r++) begin
            @(negedge clk); #1;
            if (done) begin
                lat = r;
                break;
            end
            if (junk) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom_range(0, 3));
                from_sq   = 6'($urandom_range(0, 63));
                to_sq     = 6'($urandom_range(0, 63));
                color     = 4'($urandom_range(0, 15));
            end else begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        chk("latency", 32'(lat), 32'(done_rel));
        @(negedge clk); #1;
    endtask

    initial begin
        int lat;
        int bad;
        int cols[5] = '{0, 1, 2, 4, 8};
        int op;
        int f;
        int t;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; from_sq = '0; to_sq = '0; color = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk); #1;
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // INIT
        do_cmd(3, 0, 0, 0, 1'b1, lat);
        chk("init_lat", 32'(lat), 32'd65);
        chk("init_sq0", mem[0], 32'h86);
        chk("init_sq4", mem[4], 32'h8A);
        chk("init_sq63", mem[63], 32'h87);
        chk("init_sq20", mem[20], 32'h8E);

        // MOVE 12 -> 28
        do_cmd(0, 12, 28, 0, 1'b1, lat);
        chk("move_lat", 32'(lat), 32'd4);
        chk("move_to", mem[28], 32'h40);
        chk("move_from", mem[12], 32'h4E);

        // HIGHLIGHT red then restore
        poke(9, 'h82);
        do_cmd(1, 0, 9, 2, 1'b1, lat);
        chk("hl_lat", 32'(lat), 32'd3);
        chk("hl_red", mem[9], 32'h22);
        do_cmd(1, 0, 9, 0, 1'b0, lat);
        chk("hl_base", mem[9], 32'h82);

        // Three highlights then CLEAR_HL
        do_cmd(1, 0, 0, 2, 1'b0, lat);
        do_cmd(1, 0, 35, 1, 1'b0, lat);
        do_cmd(1, 0, 50, 8, 1'b1, lat);
        do_cmd(2, 0, 0, 0, 1'b1, lat);
        chk("clear_lat", 32'(lat), 32'd193);
        bad = 0;
        for (int i = 0; i < 64; i++) if (32'(mem[i][7:4]) != 32'(base_c(i))) bad++;
        chk("clear_colours", 32'(bad), 32'd0);

        // Null move
        do_cmd(0, 5, 5, 0, 1'b1, lat);
        chk("null_move_lat", 32'(lat), 32'd1);

        // CLEAR_HL aborted by reset at square 30, with a command held while busy
        do_cmd(1, 0, 30, 4, 1'b0, lat);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        model_accept(2, 0, 0, 0);
        for (int r = 0; r <= 91; r++) begin
            @(negedge clk); #1;
            cmd_valid = (r >= 80);
            cmd_op    = 2'd0;
            from_sq   = 6'd0;
            to_sq     = 6'd63;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        expq.delete();
        done_rel = -1;
        check_reset_outputs("abort");
        @(negedge clk); #1;
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        chk("abort_sq29_cleared", 32'(mem[29][7:4]), 32'(base_c(29)));
        chk("abort_sq30_kept", 32'(mem[30][7:4]), 32'h4);
        repeat (5) @(negedge clk);
        #1;
        chk("abort_ready", 32'(cmd_ready), 32'd1);

        // Random commands
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 9);
            op = (op < 4) ? 0 : (op < 8) ? 1 : (op == 8) ? 2 : 3;
            f  = $urandom_range(0, 63);
            t  = ($urandom_range(0, 4) == 0) ? f : $urandom_range(0, 63);
            do_cmd(op, f, t, cols[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #1;
        end

        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 32'(ref_mem[i])) bad++;
        chk("mem_final", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/board_writer.md
BOARD_WRITER -- requirements
Module: board_writer

Interface
REQ-001 Port iCLK, input, 1 bit: single clock; every register is updated on its rising edge.
REQ-002 Port iRST_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 Port iCmd_valid, input, 1 bit: a command is presented.
REQ-004 Port oCmd_ready, output, 1 bit: the block can accept a command.
REQ-005 Port iCmd_op, input, 2 bits: 00 MOVE, 01 HIGHLIGHT, 10 CLEAR_HL, 11 INIT.
REQ-006 Port iFrom, input, 6 bits: source square index {row[2:0], col[2:0]}.
REQ-007 Port iTo, input, 6 bits: destination square for MOVE; target square for HIGHLIGHT.
REQ-008 Port iColor, input, 4 bits: one-hot square colour for HIGHLIGHT (8 black, 4 white, 2 red, 1 green).
REQ-009 Port oMemAddr, output, 12 bits: board memory word address.
REQ-010 Port oMemWData, output, 32 bits: board memory write data.
REQ-011 Port oMemWE, output, 1 bit: write strobe.
REQ-012 Port iMemRData, input, 32 bits: read data, valid one cycle after the address is presented with oMemWE=0.
REQ-013 Port oBusy, output, 1 bit: high while a command is executing.
REQ-014 Port oDone, output, 1 bit: one-cycle pulse at command completion.

Function
REQ-015 The board word format SHALL be:
- [0] piece colour (0 white, 1 black).
- [3:1] piece type (0 pawn, 1 knight, 2 bishop, 3 rook, 4 queen, 5 king, 7 empty).
- [7:4] square colour, one-hot.
- [31:8] written as 0.
REQ-016 oMemAddr SHALL be {6'b0, row[2:0], col[2:0]}.
REQ-017 The base square colour SHALL be 4'b1000 when (row+col) is even and 4'b0100 when it is odd.
REQ-018 Handshake and states:
- oCmd_ready SHALL be high only in IDLE.
- A command SHALL be accepted when iCmd_valid & oCmd_ready; iCmd_op, iFrom, iTo and iColor are latched on that edge.
- oBusy SHALL be the inverse of oCmd_ready.
REQ-019 MOVE SHALL run RD_FROM, WAIT, WR_TO, WR_FROM, DONE, one cycle each:
- WR_TO writes {24'b0, base colour of To, From[3:0] bits}.
- WR_FROM writes {24'b0, base colour of From, 3'b111, 1'b0}.
REQ-020 MOVE with iFrom == iTo SHALL perform no memory access; oDone SHALL pulse the cycle after acceptance.
REQ-021 HIGHLIGHT SHALL run RD, WAIT, WR, DONE:
- WR writes the read word with [7:4] replaced by the latched iColor.
- Bits [3:0] are unchanged.
- iColor = 0 SHALL write the base colour instead.
REQ-022 CLEAR_HL SHALL sweep squares 0..63 in ascending order, doing RD, WAIT, WR per square; each WR restores the base colour and keeps bits [3:0].
REQ-023 INIT SHALL write squares 0..63, one per cycle, with no reads:
- Row 0: R N B Q K B N R, colour 0.
- Row 1: pawns, colour 0.
- Row 6: pawns, colour 1.
- Row 7: R N B Q K B N R, colour 1.
- Rows 2-5: type 111, colour 0.
- All squares: base colour.
REQ-024 The sweep counter SHALL be 6 bits; the sweep ends after square 63 with no wrap or extra write.
REQ-025 oMemWE SHALL be high only in write states; in all other states oMemWData SHALL be 0.
REQ-026 oDone SHALL be high exactly one cycle, in the DONE state; the next cycle returns to IDLE with oCmd_ready=1.
REQ-027 Command latencies from the acceptance edge to oDone high:
- MOVE: 4 cycles.
- HIGHLIGHT: 3 cycles.
- CLEAR_HL: 193 cycles.
- INIT: 65 cycles.
REQ-028 Inputs presented while oBusy=1 SHALL be ignored and SHALL NOT be queued.

Reset
REQ-029 While iRST_n=0 at a clock edge, the state SHALL go to IDLE and outputs SHALL be:
- oMemWE=0, oDone=0, oMemAddr=0, oMemWData=0.
- oBusy=0, oCmd_ready=1.
REQ-030 Reset mid-command SHALL abort the command with no further writes and no oDone pulse.

Verification
REQ-031 INIT -> exactly 64 writes:
- addr 0 data 0x86 (white rook on black square).
- addr 4 data 0x8A (white king).
- addr 63 data 0x87 (black rook on black square).
- addr 20 data 0x8E (empty).
- oDone at cycle 65.
REQ-032 MOVE From=12 To=28, memory word 12 = 0x40 (white pawn on white) -> writes addr 28 = 0x40, then addr 12 = 0x4E; oDone at cycle 4.
REQ-033 HIGHLIGHT To=9, iColor=2, word 9 = 0x82 -> writes addr 9 = 0x22; then HIGHLIGHT iColor=0 -> writes 0x82.
REQ-034 CLEAR_HL after three highlights -> 64 writes, every word's [7:4] equal to its base colour; oDone at cycle 193.
REQ-035 MOVE From=To=5 -> no oMemWE pulse; oDone one cycle after acceptance.
REQ-036 iRST_n low during CLEAR_HL at square 30 -> no writes after reset, no oDone, oCmd_ready=1 on the next cycle; a new command held while busy is never executed.
